// File: rtl/dmem_write_buffer_pkg.sv
// Shared defaults for the data-memory posted-write buffer.
// Buffer depth and the address/data widths used by the core's data-memory port.
package dmem_write_buffer_pkg;

    localparam int WBUF_DEPTH = 4;
    localparam int DEF_AW     = 32;
    localparam int DEF_DW     = 32;

endpackage

// File: rtl/dmem_write_buffer_wbuf_match.sv
// Address match across the buffer entries; picks the youngest valid entry.
// Age is measured from head, so entries with age >= count are treated as empty.
module dmem_write_buffer_wbuf_match
    import dmem_write_buffer_pkg::*;
#(
    parameter int DEPTH = WBUF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic [AW-1:0]              addr_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    input  logic [$clog2(DEPTH+1)-1:0] count_i,
    input  logic [AW-1:0]              query_i,
    output logic                       hit_o,
    output logic [$clog2(DEPTH)-1:0]   hit_idx_o,
    output logic                       hit_is_head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0] age;
    logic [PW-1:0] best_age;

    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        best_age  = '0;
        age       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age = PW'(i) - head_i;
            if ((CW'(age) < count_i) && (addr_i[i] == query_i) &&
                (!hit_o || (age > best_age))) begin
                hit_o     = 1'b1;
                hit_idx_o = PW'(i);
                best_age  = age;
            end
        end
    end

    assign hit_is_head_o = hit_o && (hit_idx_o == head_i);

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the core data port and the data RAM.
// Stores retire into a FIFO drained over req/ack; loads forward from the youngest matching store.
module dmem_write_buffer
    import dmem_write_buffer_pkg::*;
#(
    parameter int DEPTH = WBUF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_memory_read,
    input  logic                       data_memory_write,
    input  logic [AW-1:0]              data_memory_a,
    input  logic [DW-1:0]              data_memory_out_v,
    output logic [DW-1:0]              data_memory_in_v,
    input  logic                       halt_f,
    output logic [AW-1:0]              mem_rd_a,
    input  logic [DW-1:0]              mem_rd_v,
    output logic                       mem_wr_req,
    output logic [AW-1:0]              mem_wr_a,
    output logic [DW-1:0]              mem_wr_v,
    input  logic                       mem_wr_ack,
    output logic [$clog2(DEPTH+1)-1:0] wbuf_count,
    output logic                       wbuf_full,
    output logic                       overflow_err,
    output logic                       drained
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          hit;
    logic [PW-1:0] hit_idx;
    logic          hit_is_head;
    logic          pop;
    logic          coalesce;
    logic          slot_free;
    logic          push;
    logic          drop;
    logic          rd_strobe_unused;

    // Loads and stores share one address port, so a single matcher serves both paths.
    dmem_write_buffer_wbuf_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_match (
        .addr_i        (addr_q),
        .head_i        (head_q),
        .count_i       (count_q),
        .query_i       (data_memory_a),
        .hit_o         (hit),
        .hit_idx_o     (hit_idx),
        .hit_is_head_o (hit_is_head)
    );

    assign mem_wr_req = (count_q != '0);
    assign pop        = mem_wr_req && mem_wr_ack;
    // The head may already be in flight to the RAM, so it is never merged into.
    assign coalesce   = data_memory_write && hit && !hit_is_head;
    assign slot_free  = (count_q < CW'(DEPTH)) || pop;
    assign push       = data_memory_write && !coalesce && slot_free;
    assign drop       = data_memory_write && !coalesce && !slot_free;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q | drop;
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= data_memory_a;
            data_q[tail_q] <= data_memory_out_v;
        end else if (coalesce) begin
            data_q[hit_idx] <= data_memory_out_v;
        end
    end

    // The read strobe does not gate the load mux; data is returned every cycle.
    assign rd_strobe_unused = data_memory_read;

    assign data_memory_in_v = hit ? data_q[hit_idx] : mem_rd_v;
    assign mem_rd_a         = data_memory_a;
    assign mem_wr_a         = addr_q[head_q];
    assign mem_wr_v         = data_q[head_q];
    assign wbuf_count       = count_q;
    assign wbuf_full        = (count_q == CW'(DEPTH));
    assign overflow_err     = ovf_q;
    assign drained          = halt_f && (count_q == '0);

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for the data-memory write buffer (DEPTH=4).
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_dmem_write_buffer;

    logic        clk;
    logic        rst;
    logic        data_memory_read;
    logic        data_memory_write;
    logic [31:0] data_memory_a;
    logic [31:0] data_memory_out_v;
    logic [31:0] data_memory_in_v;
    logic        halt_f;
    logic [31:0] mem_rd_a;
    logic [31:0] mem_rd_v;
    logic        mem_wr_req;
    logic [31:0] mem_wr_a;
    logic [31:0] mem_wr_v;
    logic        mem_wr_ack;
    logic [2:0]  wbuf_count;
    logic        wbuf_full;
    logic        overflow_err;
    logic        drained;

    int checks = 0;
    int errors = 0;

    logic        log_en = 1'b0;
    int          log_n  = 0;
    logic [31:0] log_a [16];
    logic [31:0] log_v [16];

    dmem_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .data_memory_read  (data_memory_read),
        .data_memory_write (data_memory_write),
        .data_memory_a     (data_memory_a),
        .data_memory_out_v (data_memory_out_v),
        .data_memory_in_v  (data_memory_in_v),
        .halt_f            (halt_f),
        .mem_rd_a          (mem_rd_a),
        .mem_rd_v          (mem_rd_v),
        .mem_wr_req        (mem_wr_req),
        .mem_wr_a          (mem_wr_a),
        .mem_wr_v          (mem_wr_v),
        .mem_wr_ack        (mem_wr_ack),
        .wbuf_count        (wbuf_count),
        .wbuf_full         (wbuf_full),
        .overflow_err      (overflow_err),
        .drained           (drained)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM-side observer: records every accepted write in order.
    always @(posedge clk) begin
        if (log_en && !rst && mem_wr_req && mem_wr_ack && log_n < 16) begin
            log_a[log_n] <= mem_wr_a;
            log_v[log_n] <= mem_wr_v;
            log_n <= log_n + 1;
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        data_memory_write = 1'b1;
        data_memory_a     = a;
        data_memory_out_v = d;
        @(posedge clk); #1;
        data_memory_write = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        mem_wr_ack = 1'b0;
        halt_f     = 1'b0;
        @(posedge clk); #1;
        rst        = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (wbuf_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", wbuf_count); end
        checks++; if (mem_wr_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", mem_wr_req); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", overflow_err); end
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL rst_drained got %b exp 0", drained); end
        rst = 1'b0;
        store(32'h30, 32'h1);
        store(32'h34, 32'h2);
        store(32'h38, 32'h3);
        checks++; if (wbuf_count !== 3'd3) begin errors++; $display("FAIL mid_count got %0d exp 3", wbuf_count); end
        checks++; if (mem_wr_req !== 1'b1) begin errors++; $display("FAIL mid_req got %b exp 1", mem_wr_req); end
        rst = 1'b1;
        mem_wr_ack = 1'b1;
        @(posedge clk); #1;
        checks++; if (wbuf_count !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", wbuf_count); end
        checks++; if (mem_wr_req !== 1'b0) begin errors++; $display("FAIL rstmid_req got %b exp 0", mem_wr_req); end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_wr_ack = 1'b0;
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b exp 0", overflow_err); end
        checks++; if (wbuf_count !== 3'd0) begin errors++; $display("FAIL rstmid_count2 got %0d exp 0", wbuf_count); end
    endtask

    task automatic test_load_forward();
        do_reset();
        store(32'h10, 32'h11);
        store(32'h14, 32'h22);
        checks++; if (wbuf_count !== 3'd2) begin errors++; $display("FAIL fwd_count got %0d exp 2", wbuf_count); end
        data_memory_read = 1'b1;
        mem_rd_v = 32'hDEAD_BEEF;
        data_memory_a = 32'h10; #1;
        checks++; if (data_memory_in_v !== 32'h11) begin errors++; $display("FAIL fwd_10 got %h exp 11", data_memory_in_v); end
        data_memory_a = 32'h18; #1;
        checks++; if (data_memory_in_v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fwd_miss got %h exp deadbeef", data_memory_in_v); end
        checks++; if (mem_rd_a !== 32'h18) begin errors++; $display("FAIL rd_a got %h exp 18", mem_rd_a); end
        data_memory_a = 32'h14; #1;
        checks++; if (data_memory_in_v !== 32'h22) begin errors++; $display("FAIL fwd_14 got %h exp 22", data_memory_in_v); end
        data_memory_read = 1'b0; #1;
        checks++; if (data_memory_in_v !== 32'h22) begin errors++; $display("FAIL fwd_noread got %h exp 22", data_memory_in_v); end
    endtask

    task automatic test_head_no_coalesce();
        do_reset();
        store(32'h20, 32'h1);
        store(32'h24, 32'h2);
        store(32'h20, 32'h3);
        checks++; if (wbuf_count !== 3'd3) begin errors++; $display("FAIL head_count got %0d exp 3", wbuf_count); end
        checks++; if (mem_wr_a !== 32'h20 || mem_wr_v !== 32'h1) begin errors++; $display("FAIL head_entry got %h/%h exp 20/1", mem_wr_a, mem_wr_v); end
        store(32'h24, 32'h5);
        checks++; if (wbuf_count !== 3'd3) begin errors++; $display("FAIL coal_count got %0d exp 3", wbuf_count); end
        data_memory_read = 1'b1;
        mem_rd_v = 32'h0;
        data_memory_a = 32'h20; #1;
        checks++; if (data_memory_in_v !== 32'h3) begin errors++; $display("FAIL young_20 got %h exp 3", data_memory_in_v); end
        data_memory_a = 32'h24; #1;
        checks++; if (data_memory_in_v !== 32'h5) begin errors++; $display("FAIL coal_24 got %h exp 5", data_memory_in_v); end
        data_memory_read = 1'b0;
        mem_wr_ack = 1'b1;
        @(posedge clk); #1;
        mem_wr_ack = 1'b0;
        checks++; if (wbuf_count !== 3'd2) begin errors++; $display("FAIL pop_count got %0d exp 2", wbuf_count); end
        checks++; if (mem_wr_a !== 32'h24 || mem_wr_v !== 32'h5) begin errors++; $display("FAIL pop_head got %h/%h exp 24/5", mem_wr_a, mem_wr_v); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) store(32'h40 + 32'(4*i), 32'hA0 + 32'(i));
        checks++; if (wbuf_count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", wbuf_count); end
        checks++; if (wbuf_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", wbuf_full); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL fill_err got %b exp 0", overflow_err); end
        store(32'h50, 32'hA4);
        checks++; if (wbuf_count !== 3'd4) begin errors++; $display("FAIL drop_count got %0d exp 4", wbuf_count); end
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL drop_err got %b exp 1", overflow_err); end
        mem_rd_v = 32'h5555; data_memory_a = 32'h50; #1;
        checks++; if (data_memory_in_v !== 32'h5555) begin errors++; $display("FAIL drop_load got %h exp 5555", data_memory_in_v); end
        do_reset();
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", overflow_err); end
        for (int i = 0; i < 4; i++) store(32'h40 + 32'(4*i), 32'hA0 + 32'(i));
        mem_wr_ack = 1'b1;
        store(32'h50, 32'hA4);
        mem_wr_ack = 1'b0;
        checks++; if (wbuf_count !== 3'd4) begin errors++; $display("FAIL poppush_count got %0d exp 4", wbuf_count); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL poppush_err got %b exp 0", overflow_err); end
        checks++; if (mem_wr_a !== 32'h44) begin errors++; $display("FAIL poppush_head got %h exp 44", mem_wr_a); end
        data_memory_a = 32'h50; #1;
        checks++; if (data_memory_in_v !== 32'hA4) begin errors++; $display("FAIL poppush_load got %h exp a4", data_memory_in_v); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        log_n = 0;
        log_en = 1'b1;
        mem_wr_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            store(32'h100 + 32'(4*i), 32'h1000 + 32'(i));
            checks++; if (wbuf_count > 3'd1) begin errors++; $display("FAIL b2b_count%0d got %0d exp <=1", i, wbuf_count); end
        end
        @(posedge clk); #1;
        mem_wr_ack = 1'b0;
        log_en = 1'b0;
        checks++; if (wbuf_count !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", wbuf_count); end
        checks++; if (log_n !== 8) begin errors++; $display("FAIL b2b_nwrites got %0d exp 8", log_n); end
        for (int i = 0; i < 8 && i < log_n; i++) begin
            checks++;
            if (log_a[i] !== 32'h100 + 32'(4*i) || log_v[i] !== 32'h1000 + 32'(i)) begin
                errors++;
                $display("FAIL b2b_wr%0d got %h/%h exp %h/%h", i, log_a[i], log_v[i], 32'h100 + 32'(4*i), 32'h1000 + 32'(i));
            end
        end
    endtask

    task automatic test_drain_halt();
        do_reset();
        store(32'h60, 32'h1);
        store(32'h64, 32'h2);
        store(32'h68, 32'h3);
        halt_f = 1'b1; #1;
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL halt_drained0 got %b exp 0", drained); end
        for (int k = 0; k < 3; k++) begin
            mem_wr_ack = 1'b1;
            @(posedge clk); #1;
            mem_wr_ack = 1'b0;
            checks++; if (drained !== (k == 2)) begin errors++; $display("FAIL drain_ack%0d got %b exp %b", k, drained, (k == 2)); end
            if (k < 2) begin
                @(posedge clk); #1;
                checks++; if (drained !== 1'b0) begin errors++; $display("FAIL drain_idle%0d got %b exp 0", k, drained); end
            end
        end
        store(32'h70, 32'h9);
        checks++; if (wbuf_count !== 3'd1) begin errors++; $display("FAIL halt_store got %0d exp 1", wbuf_count); end
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL halt_store_drained got %b exp 0", drained); end
        halt_f = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        data_memory_read = 1'b0;
        data_memory_write = 1'b0;
        data_memory_a = '0;
        data_memory_out_v = '0;
        halt_f = 1'b0;
        mem_rd_v = '0;
        mem_wr_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_forward();
        test_head_no_coalesce();
        test_overflow();
        test_back_to_back();
        test_drain_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
